prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, writable program memory that replaces the fixed case-table instruction ROM. It sits between the PC and the instruction decoder. The PC supplies a byte address and the block returns a registered instruction word. Unwritten or out-of-range locations read as NOP (all zeros). A byte-wide loader port with a valid/ready handshake fills the memory at run time, and a hardware clear sweep runs after every reset.

## Interface
- `DATA_W`, 16: instruction width in bits; must be a multiple of `LOAD_W`
- `ADDR_W`, 16: PC byte-address width
- `DEPTH_LOG2`, 8: log2 of the word count (default 256 words)
- `LOAD_W`, 8: loader byte width; `BPW` = `DATA_W/LOAD_W` bytes per word

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  `ADDR_W`  byte address from the PC
- `rd_en`  in  1  read request
- `o`  out  `DATA_W`  registered instruction word
- `o_valid`  out  1  `o` holds a serviced read
- `misaligned`  out  1  registered with `o`: the read's `addr[0]` was 1
- `oob`  out  1  registered with `o`: the read's word index was ≥ 2^`DEPTH_LOG2`
- `ld_start`  in  1  begin a load at word 0; honoured only in READY
- `ld_data`  in  `LOAD_W`  loader byte, most-significant byte first
- `ld_valid`  in  1  `ld_data` is valid
- `ld_last`  in  1  the byte is the final byte of the image
- `ld_ready`  out  1  block accepts a byte this cycle
- `ld_done`  out  1  one-cycle pulse when a load completes
- `ld_count`  out  `DEPTH_LOG2+1`  words written by the last load
- `busy`  out  1  high in CLEAR or LOAD

## Operation
- **States:** CLEAR, READY, LOAD.
  - Reset forces CLEAR and sets `ptr`=0.
- **CLEAR:**
  - Writes 0 to `mem[ptr]` and increments `ptr` each cycle.
  - After writing word 2^`DEPTH_LOG2`-1, moves to READY.
- **READY:**
  - `ld_start`=1 moves to LOAD, clears `ptr`, byte counter and `ld_count`.
  - `ld_start` is ignored in CLEAR and LOAD.
- **LOAD:**
  - `ld_ready`=1. A byte is accepted when `ld_valid && ld_ready`.
  - Accepted bytes fill a `DATA_W` shift register, MSB first.
  - The word is written to `mem[ptr]`, and `ptr` and `ld_count` increment, when either:
    - the `BPW`th byte is accepted, or
    - a byte with `ld_last`=1 is accepted; the remaining low bytes are zero-padded.
  - `ld_last` accepted, or word 2^`DEPTH_LOG2`-1 written, ends the load:
    - state returns to READY;
    - `ld_done` pulses the next cycle;
    - further bytes are refused (`ld_ready`=0).
- **Read path:**
  - Word index = `addr[DEPTH_LOG2:1]`; upper address bits nonzero sets `oob`.
  - On a rising edge with `rd_en`=1 and state READY: `o_valid`=1, and `o` = `mem[index]`, or 0 if `oob`.
  - `misaligned` and `oob` are registered from the same `addr`.
  - A misaligned read still returns the word at `addr>>1`.
  - With `rd_en`=0, or state not READY: `o_valid`=0 and `o`=0 (NOP), so the core stalls on NOPs.
- **Arithmetic:**
  - `ptr` is `DEPTH_LOG2+1` bits wide. Its MSB signals "memory full" and ends CLEAR/LOAD; it never wraps into word 0.
  - `ld_count` saturates at 2^`DEPTH_LOG2`.

## Timing
- **Reset values:** `o`=0, `o_valid`=0, `misaligned`=0, `oob`=0, `ld_ready`=0, `ld_done`=0, `ld_count`=0, `busy`=1.
- **Clear duration:**
  - CLEAR lasts exactly 2^`DEPTH_LOG2` cycles after the first cycle with `rst`=0.
  - `busy` falls on the edge entering READY.
- **Read latency:** 1 cycle, with one read accepted per cycle.
- **Handshake:**
  - `ld_ready` is high in the cycle after `ld_start` is sampled, and throughout LOAD.
  - `ld_ready` has no combinational path from `ld_valid`.
- **Write timing:** the completed word is written on the edge that accepts its final byte. It is readable one cycle after returning to READY.
- **Simultaneous `rd_en` and `ld_start` in READY:** the read is serviced (`o_valid` next cycle); LOAD begins on the same edge.
- **`ld_valid` and `ld_last` on the final word slot:** the word is written and the load terminates once.
- **`rst` mid-load:** the partial word is discarded, `ld_done` is not pulsed, and the full CLEAR runs again.

## Test plan
- **Reset and clear:** `DEPTH_LOG2`=8, hold `rst` 2 cycles, then release → `busy`=1 for 256 cycles. Then read `addr`=0x0010 → `o`=0x0000, `o_valid`=1 one cycle later.
- **Load and read back:** stream bytes 0x81,0x02,0x82,0x01 with `ld_last` on the 4th → `ld_done` pulse, `ld_count`=2. Read `addr`=0 → 0x8102; `addr`=2 → 0x8201.
- **Odd-length padding and misalignment:** stream 0x0C,0x01 then 0xC0 with `ld_last` → word 1 = 0xC000. Read `addr`=3 → `o`=0xC000, `misaligned`=1.
- **Backpressure and read blocking:** drop `ld_valid` for 5 cycles between bytes → no spurious write. During LOAD with `rd_en`=1 → `o_valid`=0, `o`=0.
- **Fill to capacity:** send 512 bytes without `ld_last` → `ld_count`=256, `ld_done` pulses, `ld_ready`=0 afterwards. Read `addr`=0x0200 → `oob`=1, `o`=0.
- **Reset mid-load:** assert `rst` after 3 bytes → no `ld_done`, CLEAR reruns. Address 0 then reads 0x0000.

Source files
------------

// File: rtl/prog_mem.sv
// Writable program memory between PC and decoder: registered instruction read,
// byte-wide loader with valid/ready handshake, and a clear sweep after every reset.
module prog_mem #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int LOAD_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     addr,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     o,
   output logic                  o_valid,
   output logic                  misaligned,
   output logic                  oob,
   input  logic                  ld_start,
   input  logic [LOAD_W-1:0]     ld_data,
   input  logic                  ld_valid,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  ld_done,
   output logic [DEPTH_LOG2:0]   ld_count,
   output logic                  busy
);

   localparam int BPW   = DATA_W / LOAD_W;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;

   state_t                 state;
   logic [DEPTH_LOG2:0]    ptr;
   logic [DEPTH_LOG2:0]    ptr_inc;
   logic [BC_W-1:0]        bcnt;
   logic [DATA_W-1:0]      sh;
   logic [DATA_W-1:0]      asm_word;
   logic [DATA_W-1:0]      mem [DEPTH];

   logic                   accept;
   logic                   word_end;
   logic                   load_end;
   logic                   wr_en;
   logic [DEPTH_LOG2-1:0]  wr_idx;
   logic [DATA_W-1:0]      wr_data;
   logic [DEPTH_LOG2-1:0]  rd_idx;
   logic                   rd_oob;

   function automatic logic [DEPTH_LOG2:0] sat_inc(input logic [DEPTH_LOG2:0] v);
      if (v >= (DEPTH_LOG2+1)'(DEPTH))
         return v;
      else
         return v + 1'b1;
   endfunction

   // Bytes arrive MSB first; byte number pos lands (BPW-1-pos) slots from the bottom.
   function automatic logic [DATA_W-1:0] place_byte(input logic [LOAD_W-1:0] b,
                                                    input logic [BC_W-1:0]   pos);
      logic [DATA_W-1:0] w;
      w = DATA_W'(b);
      return w << ((BPW - 1 - int'(pos)) * LOAD_W);
   endfunction

   always_comb begin
      ptr_inc  = ptr + 1'b1;
      accept   = (state == LOAD) && ld_valid;
      asm_word = sh | place_byte(ld_data, bcnt);
      word_end = accept && (ld_last || (bcnt == BC_W'(BPW - 1)));
      load_end = word_end && (ld_last || ptr_inc[DEPTH_LOG2]);
      wr_en    = !rst && ((state == CLEAR) || word_end);
      wr_idx   = ptr[DEPTH_LOG2-1:0];
      wr_data  = (state == CLEAR) ? '0 : asm_word;
      rd_idx   = addr[DEPTH_LOG2:1];
      rd_oob   = |addr[ADDR_W-1:DEPTH_LOG2+1];
   end

   assign ld_ready = (state == LOAD);
   assign busy     = (state != READY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR;
         ptr      <= '0;
         bcnt     <= '0;
         sh       <= '0;
         ld_count <= '0;
         ld_done  <= 1'b0;
      end else begin
         ld_done <= 1'b0;
         case (state)
            CLEAR: begin
               ptr <= ptr_inc;
               if (ptr_inc[DEPTH_LOG2])
                  state <= READY;
            end
            READY: begin
               if (ld_start) begin
                  state    <= LOAD;
                  ptr      <= '0;
                  bcnt     <= '0;
                  sh       <= '0;
                  ld_count <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (word_end) begin
                     sh       <= '0;
                     bcnt     <= '0;
                     ptr      <= ptr_inc;
                     ld_count <= sat_inc(ld_count);
                     if (load_end) begin
                        state   <= READY;
                        ld_done <= 1'b1;
                     end
                  end else begin
                     sh   <= asm_word;
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Storage array is never reset; the CLEAR sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o          <= '0;
         o_valid    <= 1'b0;
         misaligned <= 1'b0;
         oob        <= 1'b0;
      end else if (rd_en && (state == READY)) begin
         o          <= rd_oob ? '0 : mem[rd_idx];
         o_valid    <= 1'b1;
         misaligned <= addr[0];
         oob        <= rd_oob;
      end else begin
         o          <= '0;
         o_valid    <= 1'b0;
         misaligned <= 1'b0;
         oob        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: clear sweep, loads with padding/backpressure,
// fill to capacity, out-of-range reads and reset during a load.
module tb_prog_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        rd_en;
   logic [15:0] o;
   logic        o_valid;
   logic        misaligned;
   logic        oob;
   logic        ld_start;
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_done;
   logic [8:0]  ld_count;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   prog_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LOAD_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .rd_en      (rd_en),
      .o          (o),
      .o_valid    (o_valid),
      .misaligned (misaligned),
      .oob        (oob),
      .ld_start   (ld_start),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .ld_done    (ld_done),
      .ld_count   (ld_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      ld_data  = b;
      ld_valid = 1'b1;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      check("ld_ready_after_start", 32'(ld_ready), 32'd1);
   endtask

   task automatic read_word(input logic [15:0] a);
      addr  = a;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic wait_clear(output int cnt, output bit done_seen);
      cnt       = 0;
      done_seen = 1'b0;
      while (busy && cnt < 1000) begin
         tick();
         cnt++;
         if (ld_done) done_seen = 1'b1;
      end
   endtask

   initial begin
      int cnt;
      bit done_seen;
      bit early;

      rst = 1'b1; addr = '0; rd_en = 1'b0; ld_start = 1'b0;
      ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      tick();
      check("rst_o",          32'(o),          32'h0);
      check("rst_o_valid",    32'(o_valid),    32'h0);
      check("rst_misaligned", 32'(misaligned), 32'h0);
      check("rst_oob",        32'(oob),        32'h0);
      check("rst_ld_ready",   32'(ld_ready),   32'h0);
      check("rst_ld_done",    32'(ld_done),    32'h0);
      check("rst_ld_count",   32'(ld_count),   32'h0);
      check("rst_busy",       32'(busy),       32'h1);

      rst = 1'b0;
      wait_clear(cnt, done_seen);
      check("clear_cycles", 32'(cnt), 32'd256);
      read_word(16'h0010);
      check("clear_rd_valid", 32'(o_valid), 32'h1);
      check("clear_rd_o",     32'(o),       32'h0);

      // Basic load: two full words
      start_load();
      send_byte(8'h81, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h82, 1'b0);
      send_byte(8'h01, 1'b1);
      check("ld1_done",  32'(ld_done),  32'h1);
      check("ld1_count", 32'(ld_count), 32'd2);
      check("ld1_ready_off", 32'(ld_ready), 32'h0);
      tick();
      check("ld1_done_pulse", 32'(ld_done), 32'h0);
      read_word(16'h0000);
      check("ld1_w0", 32'(o), 32'h8102);
      read_word(16'h0002);
      check("ld1_w1", 32'(o), 32'h8201);

      // Odd-length image, last word zero-padded
      start_load();
      send_byte(8'h0C, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hC0, 1'b1);
      check("ld2_count", 32'(ld_count), 32'd2);
      read_word(16'h0003);
      check("ld2_w1_mis", 32'(o),          32'hC000);
      check("ld2_mis",    32'(misaligned), 32'h1);
      check("ld2_oob",    32'(oob),        32'h0);
      read_word(16'h0000);
      check("ld2_w0",      32'(o),          32'h0C01);
      check("ld2_mis_off", 32'(misaligned), 32'h0);

      // Backpressure with reads attempted during LOAD
      start_load();
      send_byte(8'hAB, 1'b0);
      addr  = 16'h0000;
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_o_valid", 32'(o_valid), 32'h0);
         check("bp_o",       32'(o),       32'h0);
      end
      rd_en = 1'b0;
      check("bp_count_gap", 32'(ld_count), 32'd0);
      send_byte(8'hCD, 1'b0);
      check("bp_count_1", 32'(ld_count), 32'd1);
      send_byte(8'h11, 1'b1);
      check("bp_done",    32'(ld_done),  32'h1);
      check("bp_count_2", 32'(ld_count), 32'd2);
      tick();
      read_word(16'h0002);
      check("bp_w1", 32'(o), 32'h1100);

      // Read and load start on the same edge
      addr     = 16'h0000;
      rd_en    = 1'b1;
      ld_start = 1'b1;
      tick();
      rd_en    = 1'b0;
      ld_start = 1'b0;
      check("sim_o_valid", 32'(o_valid),  32'h1);
      check("sim_o",       32'(o),        32'hABCD);
      check("sim_ready",   32'(ld_ready), 32'h1);

      // Fill to capacity without ld_last
      early = 1'b0;
      for (int i = 0; i < 512; i++) begin
         send_byte(8'(i), 1'b0);
         if (i < 511 && (ld_done || !ld_ready)) early = 1'b1;
      end
      check("fill_early_end", 32'(early),    32'h0);
      check("fill_done",      32'(ld_done),  32'h1);
      check("fill_count",     32'(ld_count), 32'd256);
      check("fill_ready_off", 32'(ld_ready), 32'h0);
      send_byte(8'hEE, 1'b0);
      check("fill_refused",   32'(ld_count), 32'd256);
      check("fill_done_once", 32'(ld_done),  32'h0);
      read_word(16'h0200);
      check("oob_flag",  32'(oob),     32'h1);
      check("oob_o",     32'(o),       32'h0);
      check("oob_valid", 32'(o_valid), 32'h1);
      read_word(16'h01FE);
      check("fill_w255", 32'(o), 32'hFEFF);
      read_word(16'h0004);
      check("fill_w2",   32'(o), 32'h0405);

      // Reset in the middle of a load
      start_load();
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      send_byte(8'h77, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_done",  32'(ld_done),  32'h0);
      check("mrst_busy",  32'(busy),     32'h1);
      check("mrst_ready", 32'(ld_ready), 32'h0);
      check("mrst_count", 32'(ld_count), 32'd0);
      wait_clear(cnt, done_seen);
      check("mrst_clear_cycles", 32'(cnt),       32'd256);
      check("mrst_no_done",      32'(done_seen), 32'h0);
      read_word(16'h0000);
      check("mrst_w0",   32'(o), 32'h0);
      read_word(16'h01FE);
      check("mrst_w255", 32'(o), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
